core_periph_bridge: RTL and testbench
=====================================

CORE_PERIPH_BRIDGE -- requirements
Module: core_periph_bridge

Interface
REQ-001 Parameter PERIPHERAL_BASE, default 64'h2000_0000, is the lowest peripheral address.
REQ-002 Parameter TIMEOUT, default 255, is the number of WAIT cycles before the bridge aborts the access, legal range 1..65535.
REQ-003 There SHALL be one clock and one reset; reset is synchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: synchronous active-low reset.
REQ-006 Port d_valid, input, 1: the EX-stage peripheral access request from the hazard unit.
REQ-007 Port addr, input, 64: EX-stage byte address.
REQ-008 Port EX_mem_write, input, 1: 1 = store, 0 = load.
REQ-009 Port w_data, input, 64: store data.
REQ-010 Port byte_en, input, 8: store byte lanes.
REQ-011 Port EX_hold, input, 1: the EX stage is frozen by another stall source.
REQ-012 Port d_ready, output, 1: the access is complete, so the EX stall is released.
REQ-013 Port d_rdata, output, 64: load result, valid while d_ready=1.
REQ-014 Port d_err, output, 1: the access ended in a bus error or timeout, valid while d_ready=1.
REQ-015 Port p_req, output, 1: peripheral bus request.
REQ-016 Port p_we, output, 1: peripheral write enable.
REQ-017 Port p_addr, output, 32: peripheral offset.
REQ-018 Port p_wdata, output, 64: peripheral write data.
REQ-019 Port p_be, output, 8: peripheral byte enables.
REQ-020 Port p_ack, input, 1: peripheral completion.
REQ-021 Port p_rdata, input, 64: peripheral read data, sampled when p_ack=1.
REQ-022 Port p_err, input, 1: peripheral error, sampled when p_ack=1.

Function
REQ-023 The FSM SHALL have exactly four states, IDLE, REQ, WAIT and DONE, and SHALL be in IDLE after reset.
REQ-024 IDLE: when d_valid=1, the bridge SHALL register addr-PERIPHERAL_BASE (low 32 bits), EX_mem_write, w_data and byte_en, then go to REQ; otherwise it SHALL stay in IDLE.
REQ-025 REQ: p_req SHALL be 1 for one cycle, driven from the registered fields only, and the FSM SHALL then go to WAIT.
REQ-026 WAIT: p_req SHALL be 0, a timeout counter SHALL increment each cycle, and the FSM SHALL go to DONE on p_ack=1 or when the counter reaches TIMEOUT.
REQ-027 If p_ack=1 in the same cycle the counter reaches TIMEOUT, p_ack SHALL win and d_err SHALL equal p_err.
REQ-028 On p_ack, d_rdata SHALL capture p_rdata and d_err SHALL capture p_err.
REQ-029 On timeout, d_rdata SHALL be 64'h0 and d_err SHALL be 1.
REQ-030 For a store, d_rdata SHALL be 64'h0.
REQ-031 DONE: d_ready SHALL be 1; the FSM SHALL stay in DONE while EX_hold=1 and go to IDLE when EX_hold=0.
REQ-032 d_ready SHALL be 0 in IDLE, REQ and WAIT, so the minimum latency from d_valid to d_ready is 3 cycles (p_ack in the first WAIT cycle).
REQ-033 The bridge SHALL never re-issue an access while in DONE, even if d_valid stays 1.
REQ-034 A d_valid seen in the cycle after DONE SHALL be treated as a new access.
REQ-035 A p_ack arriving outside WAIT SHALL be ignored.
REQ-036 Changes on addr, w_data and d_valid after capture SHALL not affect the transaction in flight.
REQ-037 The timeout counter SHALL clear on entry to REQ and SHALL saturate, never wrapping.
REQ-038 An address offset wider than 32 bits SHALL be truncated to its low 32 bits with no error.

Reset
REQ-039 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE in that cycle, including mid-transaction, and any pending p_ack SHALL be dropped.
REQ-040 Reset SHALL clear p_req, p_we, d_ready and d_err to 0, p_addr to 0, p_wdata and d_rdata to 64'h0, p_be to 8'h00, and the timeout counter to 0.

Verification
REQ-041 Load, p_ack in the first WAIT cycle: addr=64'h2000_0010, p_rdata=64'h1234 -> p_addr=32'h10, p_we=0, p_req pulses one cycle, d_ready=1 three cycles after d_valid, d_rdata=64'h1234, d_err=0.
REQ-042 Store: addr=64'h2000_0008, w_data=64'hAA, byte_en=8'h0F, p_ack after 5 WAIT cycles -> p_we=1, p_wdata=64'hAA, p_be=8'h0F, d_ready for one cycle, d_rdata=64'h0.
REQ-043 Timeout with TIMEOUT=4 and no p_ack -> d_ready and d_err=1 after 4 WAIT cycles, d_rdata=64'h0; a late p_ack after that SHALL be ignored.
REQ-044 Back-to-back accesses with d_valid held high across two stores -> two distinct p_req pulses with one IDLE cycle between them; EX_hold=1 during DONE keeps d_ready=1 with no extra p_req.
REQ-045 rst_n=0 in WAIT -> IDLE next cycle with all outputs at reset values; a subsequent access completes normally.

Source files
------------

// File: rtl/core_periph_bridge.sv
// Bridge from the EX-stage peripheral access request to a single-outstanding
// request/acknowledge peripheral bus, with a WAIT timeout that forces a bus error.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no access pending; captures the request fields when d_valid=1
// REQ   | p_req asserted for exactly one cycle from the captured fields
// WAIT  | waiting for p_ack; timeout counter advances each cycle
// DONE  | d_ready=1 with result; held while EX_hold=1
module core_periph_bridge #(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_valid,
    input  logic [63:0] addr,
    input  logic        EX_mem_write,
    input  logic [63:0] w_data,
    input  logic [7:0]  byte_en,
    input  logic        EX_hold,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        p_req,
    output logic        p_we,
    output logic [31:0] p_addr,
    output logic [63:0] p_wdata,
    output logic [7:0]  p_be,
    input  logic        p_ack,
    input  logic [63:0] p_rdata,
    input  logic        p_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  be_q, be_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] offset;
    logic        unused_offset_hi;
    logic [15:0] cnt_inc;
    logic        cnt_hit;

    // Offsets beyond 32 bits are silently truncated to the peripheral window.
    assign offset           = addr - PERIPHERAL_BASE;
    assign unused_offset_hi = ^offset[63:32];

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // True in the WAIT cycle whose increment makes the counter reach TIMEOUT.
    assign cnt_hit = ({1'b0, cnt_q} + 17'd1) >= {1'b0, TO_LIMIT};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (d_valid) begin
                    addr_d  = offset[31:0];
                    we_d    = EX_mem_write;
                    wdata_d = w_data;
                    be_d    = byte_en;
                    cnt_d   = 16'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (p_ack) begin
                    rdata_d = we_q ? 64'h0 : p_rdata;
                    err_d   = p_err;
                    state_d = ST_DONE;
                end else if (cnt_hit) begin
                    rdata_d = 64'h0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!EX_hold) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wdata_q <= 64'h0;
            be_q    <= 8'h00;
            cnt_q   <= 16'd0;
            rdata_q <= 64'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign p_req   = (state_q == ST_REQ);
    assign d_ready = (state_q == ST_DONE);
    assign p_we    = we_q;
    assign p_addr  = addr_q;
    assign p_wdata = wdata_q;
    assign p_be    = be_q;
    assign d_rdata = rdata_q;
    assign d_err   = err_q;

endmodule

// File: tb/tb_core_periph_bridge.sv
// Randomized self-checking bench for core_periph_bridge; two instances
// (default TIMEOUT and TIMEOUT=4) share stimulus, outputs are selected by sel.
module tb_core_periph_bridge;

    localparam logic [63:0] BASE = 64'h2000_0000;

    logic        clk = 1'b0;
    logic        rst_n, d_valid, EX_mem_write, EX_hold, p_ack, p_err;
    logic [63:0] addr, w_data, p_rdata;
    logic [7:0]  byte_en;
    logic        sel;

    logic        a_d_ready, a_d_err, a_p_req, a_p_we;
    logic [63:0] a_d_rdata, a_p_wdata;
    logic [31:0] a_p_addr;
    logic [7:0]  a_p_be;
    logic        b_d_ready, b_d_err, b_p_req, b_p_we;
    logic [63:0] b_d_rdata, b_p_wdata;
    logic [31:0] b_p_addr;
    logic [7:0]  b_p_be;

    logic        o_d_ready, o_d_err, o_p_req, o_p_we;
    logic [63:0] o_d_rdata, o_p_wdata;
    logic [31:0] o_p_addr;
    logic [7:0]  o_p_be;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_periph_bridge u_dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .addr(addr),
        .EX_mem_write(EX_mem_write), .w_data(w_data), .byte_en(byte_en),
        .EX_hold(EX_hold), .d_ready(a_d_ready), .d_rdata(a_d_rdata),
        .d_err(a_d_err), .p_req(a_p_req), .p_we(a_p_we), .p_addr(a_p_addr),
        .p_wdata(a_p_wdata), .p_be(a_p_be), .p_ack(p_ack),
        .p_rdata(p_rdata), .p_err(p_err)
    );

    core_periph_bridge #(.TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .addr(addr),
        .EX_mem_write(EX_mem_write), .w_data(w_data), .byte_en(byte_en),
        .EX_hold(EX_hold), .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .d_err(b_d_err), .p_req(b_p_req), .p_we(b_p_we), .p_addr(b_p_addr),
        .p_wdata(b_p_wdata), .p_be(b_p_be), .p_ack(p_ack),
        .p_rdata(p_rdata), .p_err(p_err)
    );

    assign o_d_ready = sel ? b_d_ready : a_d_ready;
    assign o_d_err   = sel ? b_d_err   : a_d_err;
    assign o_p_req   = sel ? b_p_req   : a_p_req;
    assign o_p_we    = sel ? b_p_we    : a_p_we;
    assign o_d_rdata = sel ? b_d_rdata : a_d_rdata;
    assign o_p_wdata = sel ? b_p_wdata : a_p_wdata;
    assign o_p_addr  = sel ? b_p_addr  : a_p_addr;
    assign o_p_be    = sel ? b_p_be    : a_p_be;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_d_ready"}, 64'(o_d_ready), 64'd0);
        chk({tag, "_d_err"},   64'(o_d_err),   64'd0);
        chk({tag, "_p_req"},   64'(o_p_req),   64'd0);
        chk({tag, "_p_we"},    64'(o_p_we),    64'd0);
        chk({tag, "_p_addr"},  64'(o_p_addr),  64'd0);
        chk({tag, "_p_wdata"}, o_p_wdata,      64'd0);
        chk({tag, "_d_rdata"}, o_d_rdata,      64'd0);
        chk({tag, "_p_be"},    64'(o_p_be),    64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; d_valid = 1'b0; p_ack = 1'b0; EX_hold = 1'b0; p_err = 1'b0;
        addr = 64'h0; w_data = 64'h0; byte_en = 8'h00; EX_mem_write = 1'b0; p_rdata = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One access from the IDLE cycle through DONE; entered and left at posedge+1.
    // ack_at: WAIT cycle (1-based) in which p_ack is driven, 0 = never.
    task automatic run_txn(input bit st, input logic [63:0] off, input logic [63:0] wd,
                           input logic [7:0] be, input int ack_at, input logic [63:0] rd,
                           input bit er, input int hold, input bit keep_valid,
                           input bit late_ack, input int tmo);
        int          exp_waits;
        bit          timed_out;
        logic [63:0] exp_rd;
        logic        exp_err;
        timed_out = !(ack_at != 0 && ack_at <= tmo);
        exp_waits = timed_out ? tmo : ack_at;
        exp_rd    = (st || timed_out) ? 64'h0 : rd;
        exp_err   = timed_out ? 1'b1 : er;

        d_valid = 1'b1; addr = BASE + off; EX_mem_write = st; w_data = wd; byte_en = be;
        p_ack = 1'b0; EX_hold = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(o_d_ready), 64'd0);
        chk("idle_req",   64'(o_p_req),   64'd0);

        tick();
        d_valid = keep_valid; addr = {$urandom, $urandom}; w_data = {$urandom, $urandom};
        byte_en = 8'($urandom); EX_mem_write = ~st;
        @(negedge clk);
        chk("req_pulse", 64'(o_p_req),   64'd1);
        chk("req_addr",  64'(o_p_addr),  64'(off[31:0]));
        chk("req_we",    64'(o_p_we),    64'(st));
        chk("req_wdata", o_p_wdata,      wd);
        chk("req_be",    64'(o_p_be),    64'(be));
        chk("req_ready", 64'(o_d_ready), 64'd0);

        for (int i = 1; i <= exp_waits; i++) begin
            tick();
            p_ack   = (i == ack_at);
            p_rdata = (i == ack_at) ? rd : {$urandom, $urandom};
            p_err   = (i == ack_at) ? er : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wait_req",   64'(o_p_req),   64'd0);
            chk("wait_ready", 64'(o_d_ready), 64'd0);
        end

        tick();
        p_ack = late_ack; p_rdata = {$urandom, $urandom} | 64'h1; p_err = ~exp_err;
        EX_hold = (hold > 0);
        @(negedge clk);
        chk("done_ready", 64'(o_d_ready), 64'd1);
        chk("done_rdata", o_d_rdata,      exp_rd);
        chk("done_err",   64'(o_d_err),   64'(exp_err));
        chk("done_req",   64'(o_p_req),   64'd0);

        for (int h = 0; h < hold; h++) begin
            tick();
            p_ack = 1'($urandom_range(0, 1));
            EX_hold = (h < hold - 1);
            @(negedge clk);
            chk("hold_ready", 64'(o_d_ready), 64'd1);
            chk("hold_req",   64'(o_p_req),   64'd0);
            chk("hold_rdata", o_d_rdata,      exp_rd);
            chk("hold_err",   64'(o_d_err),   64'(exp_err));
        end

        tick();
        p_ack = 1'b0; EX_hold = 1'b0;
    endtask

    task automatic rand_txn(input int tmo, input int ack_lo, input int ack_hi);
        bit          st;
        logic [63:0] off;
        st  = 1'($urandom_range(0, 1));
        off = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : {32'h0, $urandom};
        run_txn(st, off, {$urandom, $urandom}, 8'($urandom),
                $urandom_range(ack_lo, ack_hi), {$urandom, $urandom},
                1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tmo);
    endtask

    initial begin
        sel = 1'b0;
        do_reset();
        @(negedge clk);
        check_rst("rst_a");
        sel = 1'b1;
        check_rst("rst_b");
        sel = 1'b0;
        tick();

        // load with ack in the first WAIT cycle
        run_txn(1'b0, 64'h10, 64'h0, 8'hFF, 1, 64'h1234, 1'b0, 0, 1'b0, 1'b0, 255);
        // store acked after five WAIT cycles
        run_txn(1'b1, 64'h8, 64'hAA, 8'h0F, 6, 64'hDEAD, 1'b0, 0, 1'b0, 1'b0, 255);
        // back-to-back stores with d_valid held, second held in DONE
        run_txn(1'b1, 64'h20, 64'h11, 8'h01, 2, 64'h0, 1'b0, 0, 1'b1, 1'b0, 255);
        run_txn(1'b1, 64'h28, 64'h22, 8'h03, 1, 64'h0, 1'b1, 2, 1'b1, 1'b0, 255);
        d_valid = 1'b0;
        // full-length timeout and ack on the final WAIT cycle
        run_txn(1'b0, 64'h30, 64'h0, 8'h00, 0, 64'h5555, 1'b0, 1, 1'b0, 1'b1, 255);
        run_txn(1'b0, 64'h38, 64'h0, 8'h00, 255, 64'h7777, 1'b0, 0, 1'b0, 1'b0, 255);
        // offset wider than 32 bits is truncated
        run_txn(1'b0, 64'h0000_0003_0000_0044, 64'h0, 8'h00, 3, 64'h99, 1'b1, 0, 1'b0, 1'b0, 255);
        for (int k = 0; k < 40; k++) rand_txn(255, 1, 7);
        d_valid = 1'b0;

        sel = 1'b1;
        do_reset();
        // timeout with TIMEOUT=4, late ack in DONE ignored
        run_txn(1'b0, 64'h50, 64'h0, 8'h00, 0, 64'hBEEF, 1'b0, 2, 1'b0, 1'b1, 4);
        // ack on the cycle the counter reaches TIMEOUT wins
        run_txn(1'b0, 64'h58, 64'h0, 8'h00, 4, 64'hCAFE, 1'b0, 0, 1'b0, 1'b0, 4);
        run_txn(1'b0, 64'h60, 64'h0, 8'h00, 5, 64'hF00D, 1'b0, 0, 1'b0, 1'b0, 4);
        for (int k = 0; k < 40; k++) rand_txn(4, 0, 6);
        d_valid = 1'b0;

        // reset while in WAIT with a pending ack
        run_txn(1'b0, 64'h70, 64'h0, 8'h00, 1, 64'hABCD, 1'b1, 0, 1'b0, 1'b0, 4);
        d_valid = 1'b1; addr = BASE + 64'h40; EX_mem_write = 1'b1;
        w_data = 64'h1234_5678; byte_en = 8'hF0;
        tick();
        d_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0; p_ack = 1'b1; p_rdata = 64'h4444; p_err = 1'b1;
        tick();
        rst_n = 1'b1; p_ack = 1'b0;
        @(negedge clk);
        check_rst("wait_rst");
        tick();
        run_txn(1'b0, 64'h48, 64'h0, 8'h00, 2, 64'h8888, 1'b0, 0, 1'b0, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
